// File: rtl/solve_cooling_pkg.sv
// solve_cooling_pkg: shared mode encoding and saturation-bound helper for the fixed-point multiplier
package solve_cooling_pkg;
  localparam int MAXW = 130;
  typedef enum logic {MODE_UNSIGNED = 1'b0, MODE_SIGNED = 1'b1} mode_e;
  typedef struct packed {
    logic [MAXW-1:0] hi;
    logic [MAXW-1:0] lo;
  } bounds_t;
  function automatic bounds_t sat_bounds(input int w, input logic sgn);
    logic signed [MAXW-1:0] one;
    bounds_t b;
    one = MAXW'(1);
    b.hi = sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
    b.lo = sgn ? -(one <<< (w - 1)) : '0;
    return b;
  endfunction
endpackage

// File: rtl/solve_cooling_round_sat.sv
// solve_cooling_round_sat: round half-up, scale down by SHIFT, then clamp or truncate to DOUT_WIDTH
module solve_cooling_round_sat
  import solve_cooling_pkg::*;
#(
  parameter int PW         = 65,
  parameter int DOUT_WIDTH = 32,
  parameter int SHIFT      = 16,
  parameter bit SATURATE   = 1'b1
) (
  input  logic [PW-1:0]         prod_i,
  input  logic                  sgn_i,
  output logic [DOUT_WIDTH-1:0] dout_o,
  output logic                  ovf_o
);
  localparam int W = PW + 1;
  localparam logic [W-1:0] RND = (SHIFT == 0) ? '0 : W'(1) << (SHIFT > 0 ? SHIFT - 1 : 0);
  logic signed [W-1:0] sum, r;
  logic signed [MAXW-1:0] rx, hi, lo;
  bounds_t bnd;
  logic over, under;
  // The product is always a valid signed PW-bit value, so one signed datapath serves both modes
  always_comb begin
    sum = $signed({prod_i[PW-1], prod_i}) + $signed(RND);
    r = sum >>> SHIFT;
    rx = {{(MAXW-W){r[W-1]}}, r};
    bnd = sat_bounds(DOUT_WIDTH, sgn_i == MODE_SIGNED);
    hi = bnd.hi;
    lo = bnd.lo;
    over = rx > hi;
    under = rx < lo;
    dout_o = !SATURATE ? rx[DOUT_WIDTH-1:0] : over ? hi[DOUT_WIDTH-1:0] : under ? lo[DOUT_WIDTH-1:0] : rx[DOUT_WIDTH-1:0];
    ovf_o = over || under;
  end
endmodule

// File: rtl/solve_cooling_mul_pipe.sv
// solve_cooling_mul_pipe: pipelined fixed-point multiplier with rounding, saturation and ready/valid flow control
module solve_cooling_mul_pipe
  import solve_cooling_pkg::*;
#(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 32,
  parameter int DOUT_WIDTH = 32,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 16,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);
  localparam int P = DIN0_WIDTH + DIN1_WIDTH + 1;
  logic adv, sgn;
  logic signed [P-1:0] a_ext, b_ext, prod_d;
  logic [P-1:0] fin_p;
  logic fin_s, fin_v;
  logic [DOUT_WIDTH-1:0] rs_dout, dout_q;
  logic rs_ovf, ovf_q, out_valid_q;
  assign adv = ce && (!out_valid_q || out_ready);
  assign in_ready = adv;
  assign sgn = is_signed == MODE_SIGNED;
  assign a_ext = {{(P-DIN0_WIDTH){sgn & din0[DIN0_WIDTH-1]}}, din0};
  assign b_ext = {{(P-DIN1_WIDTH){sgn & din1[DIN1_WIDTH-1]}}, din1};
  assign prod_d = a_ext * b_ext;
  if (NUM_STAGE == 1) begin : g_direct
    assign fin_p = prod_d;
    assign fin_s = is_signed;
    assign fin_v = in_valid;
  end else begin : g_pipe
    logic [P-1:0] p_q [NUM_STAGE-1];
    logic [NUM_STAGE-2:0] s_q, v_q;
    // Valid bits travel with the data so bubbles stay in place; reset flushes in-flight work
    always_ff @(posedge clk or posedge reset) begin
      if (reset) v_q <= '0;
      else if (adv) begin
        v_q[0] <= in_valid;
        for (int i = 1; i < NUM_STAGE - 1; i++) v_q[i] <= v_q[i-1];
      end
    end
    // Product and mode registers without reset so the retiming chain can fold into DSP pipeline regs
    always_ff @(posedge clk) begin
      if (adv) begin
        p_q[0] <= prod_d;
        s_q[0] <= is_signed;
        for (int i = 1; i < NUM_STAGE - 1; i++) begin
          p_q[i] <= p_q[i-1];
          s_q[i] <= s_q[i-1];
        end
      end
    end
    assign fin_p = p_q[NUM_STAGE-2];
    assign fin_s = s_q[NUM_STAGE-2];
    assign fin_v = v_q[NUM_STAGE-2];
  end
  solve_cooling_round_sat #(
    .PW(P), .DOUT_WIDTH(DOUT_WIDTH), .SHIFT(SHIFT), .SATURATE(SATURATE)
  ) u_round_sat (
    .prod_i(fin_p), .sgn_i(fin_s), .dout_o(rs_dout), .ovf_o(rs_ovf)
  );
  // Output stage holds its result while the consumer stalls or ce is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= fin_v;
      dout_q <= rs_dout;
      ovf_q <= rs_ovf;
    end
  end
  assign out_valid = out_valid_q;
  assign dout = dout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_solve_cooling_mul_pipe.sv
// tb_solve_cooling_mul_pipe: directed table vectors plus backpressure, ce-freeze and reset sequences
module tb_solve_cooling_mul_pipe;
  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        eo;
  } vec_t;
  localparam int NV = 21;
  logic clk = 1'b0, reset = 1'b1, ce = 1'b1, in_valid = 1'b0, out_ready = 1'b1, is_signed = 1'b0;
  logic in_ready, out_valid, ovf;
  logic [31:0] din0 = '0, din1 = '0, dout;
  int ncmp = 0, nerr = 0;
  vec_t tbl [NV];
  solve_cooling_mul_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    is_signed = v.sgn;
    din0 = v.a;
    din1 = v.b;
    in_valid = 1'b1;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 32'h00018000, 32'h00020000, 32'h00030000, 1'b0};
    tbl[1]  = '{1'b1, 32'hFFFE8000, 32'h00020000, 32'hFFFD0000, 1'b0};
    tbl[2]  = '{1'b1, 32'h00000001, 32'h00008000, 32'h00000001, 1'b0};
    tbl[3]  = '{1'b1, 32'hFFFFFFFF, 32'h00008000, 32'h00000000, 1'b0};
    tbl[4]  = '{1'b1, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFFFFFF, 1'b1};
    tbl[5]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    tbl[6]  = '{1'b1, 32'h80000000, 32'h7FFF0000, 32'h80000000, 1'b1};
    tbl[7]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00010000, 1'b0};
    tbl[8]  = '{1'b0, 32'h00020000, 32'hFFFF0000, 32'hFFFFFFFF, 1'b1};
    tbl[9]  = '{1'b0, 32'hFFFF0000, 32'h00010000, 32'hFFFF0000, 1'b0};
    tbl[10] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    tbl[11] = '{1'b0, 32'h80000000, 32'h00000002, 32'h00010000, 1'b0};
    tbl[12] = '{1'b1, 32'hFFFFFFFF, 32'h00008001, 32'hFFFFFFFF, 1'b0};
    tbl[13] = '{1'b1, 32'h00008000, 32'h00008000, 32'h00004000, 1'b0};
    tbl[14] = '{1'b1, 32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b0};
    tbl[15] = '{1'b1, 32'h80000000, 32'h00010000, 32'h80000000, 1'b0};
    tbl[16] = '{1'b1, 32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b1};
    tbl[17] = '{1'b0, 32'h00000001, 32'h00008000, 32'h00000001, 1'b0};
    tbl[18] = '{1'b0, 32'h00000001, 32'h00007FFF, 32'h00000000, 1'b0};
    tbl[19] = '{1'b1, 32'h80000000, 32'h00020000, 32'h80000000, 1'b1};
    tbl[20] = '{1'b0, 32'h80000000, 32'h00020000, 32'hFFFFFFFF, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    // table vectors, one at a time, latency checked on each
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(tbl[k]);
      #1 chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_lat1_valid", k), 32'(out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_lat2_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_dout", k), dout, tbl[k].exp);
      chk($sformatf("v%0d_ovf", k), 32'(ovf), 32'(tbl[k].eo));
    end
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);
    // backpressure stream: out_ready pattern 1,0,0,1
    begin
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] held = '0;
      logic hold_v = 1'b0;
      int sent = 0, got = 0;
      for (int c = 0; c < 100 && got < 8; c++) begin
        @(negedge clk);
        if (hold_v) chk("bp_stable", dout, held);
        out_ready = pat[c % 4];
        if (sent < 8) drive(tbl[sent]);
        else in_valid = 1'b0;
        #1;
        if (out_valid && !out_ready) chk("bp_stall_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          chk($sformatf("bp_res%0d", got), dout, tbl[got].exp);
          got++;
        end
        hold_v = out_valid && !out_ready;
        held = dout;
        if (in_valid && in_ready) sent++;
      end
      chk("bp_count", 32'(got), 32'd8);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
    end
    // ce freeze with two results in flight
    begin
      logic [31:0] fd;
      @(negedge clk);
      drive(tbl[0]);
      @(negedge clk);
      drive(tbl[1]);
      @(negedge clk);
      drive(tbl[2]);
      ce = 1'b0;
      fd = dout;
      for (int i = 0; i < 3; i++) begin
        #1 chk("ce_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ce_valid_hold", 32'(out_valid), 32'd1);
        chk("ce_dout_hold", dout, fd);
      end
      ce = 1'b1;
      in_valid = 1'b0;
      chk("ce_res0", dout, tbl[0].exp);
      @(negedge clk);
      chk("ce_res1", dout, tbl[1].exp);
      chk("ce_res1_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      chk("ce_after_valid", 32'(out_valid), 32'd0);
    end
    // reset with two results in flight
    @(negedge clk);
    drive(tbl[4]);
    @(negedge clk);
    drive(tbl[5]);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_flight_valid", 32'(out_valid), 32'd0);
    chk("rst_flight_dout", dout, 32'd0);
    chk("rst_flight_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 32'(out_valid), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(tbl[13]);
    #1 chk("rst_first_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_first_valid", 32'(out_valid), 32'd1);
    chk("rst_first_dout", dout, tbl[13].exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
